// File: rtl/wind_rec2pol.sv
`default_nettype none
// ============================================================================
//  Module      : wind_rec2pol
//  Description : Rectangular (speedX, speedY) to polar (speed, direction)
//                converter using an iterative vectoring CORDIC.
//  Revision    : 1.0 - initial release
// ============================================================================
module wind_rec2pol #(
    parameter int DW   = 16,
    parameter int ITER = 14,
    parameter int AW   = 24
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] xspeed,
    input  logic [DW-1:0] yspeed,
    output logic          busy,
    output logic          overrun,
    output logic          out_valid,
    output logic [DW-1:0] speed,
    output logic [DW-1:0] direction
);

    // Fractional guard bits below the input LSB keep the truncation of the
    // arithmetic shifts from eating into output accuracy on small vectors.
    localparam int GB = 8;
    localparam int XW = DW + 3 + GB;
    localparam int ZF = 16;
    localparam int ZW = AW + 2;
    localparam int CW = 5;
    localparam int PW = XW + 16;

    localparam logic [15:0]          GAIN     = 16'd39797;
    localparam logic [PW-1:0]        MAG_HALF = PW'(1) << (15 + GB);
    localparam logic signed [ZW-1:0] Z180     = ZW'(180 * 65536);
    localparam logic signed [ZW-1:0] Z360     = ZW'(360 * 65536);
    localparam logic signed [ZW-1:0] DIR_HALF = ZW'(1 << (ZF - 8));
    localparam logic signed [ZW-1:0] DIR_FULL = ZW'(360 * 128);
    localparam logic [XW-1:0]        MAG_MAX  = XW'((1 << DW) - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // atan(2^-i) in degrees, 16 fractional bits
    function automatic logic [AW-1:0] atan_lut(input logic [CW-1:0] i);
        case (i)
            5'd0:    atan_lut = AW'(2949120);
            5'd1:    atan_lut = AW'(1740967);
            5'd2:    atan_lut = AW'(919879);
            5'd3:    atan_lut = AW'(466945);
            5'd4:    atan_lut = AW'(234379);
            5'd5:    atan_lut = AW'(117304);
            5'd6:    atan_lut = AW'(58666);
            5'd7:    atan_lut = AW'(29335);
            5'd8:    atan_lut = AW'(14668);
            5'd9:    atan_lut = AW'(7334);
            5'd10:   atan_lut = AW'(3667);
            5'd11:   atan_lut = AW'(1833);
            5'd12:   atan_lut = AW'(917);
            5'd13:   atan_lut = AW'(458);
            5'd14:   atan_lut = AW'(229);
            5'd15:   atan_lut = AW'(115);
            default: atan_lut = '0;
        endcase
    endfunction

    function automatic logic signed [XW-1:0] ext(input logic [DW-1:0] v);
        ext = {{3{v[DW-1]}}, v, {GB{1'b0}}};
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic                 zero_q, zero_d;
    logic                 pend_full_q, pend_full_d;
    logic [DW-1:0]        pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [DW-1:0]        mag_q, mag_d, dir_q, dir_d;
    logic [DW-1:0]        speed_q, speed_d, direction_q, direction_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;

    logic signed [XW-1:0] w_xs, w_ys;
    logic signed [ZW-1:0] w_atan;
    logic [PW-1:0]        w_prod, w_mag_round;
    logic [XW-1:0]        w_mag_full;
    logic signed [ZW-1:0] w_zpos, w_dir_full;
    logic                 w_consume;

    always_comb begin
        w_xs        = x_q >>> cnt_q;
        w_ys        = y_q >>> cnt_q;
        w_atan      = $signed({2'b00, atan_lut(cnt_q)});
        w_prod      = {16'd0, x_q} * {{XW{1'b0}}, GAIN};
        w_mag_round = w_prod + MAG_HALF;
        w_mag_full  = XW'(w_mag_round >> (16 + GB));
        w_zpos      = z_q[ZW-1] ? (z_q + Z360) : z_q;
        w_dir_full  = (w_zpos + DIR_HALF) >>> (ZF - 7);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        pend_full_d = pend_full_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        mag_d       = mag_q;
        dir_d       = dir_q;
        speed_d     = speed_q;
        direction_d = direction_q;
        out_valid_d = 1'b0;
        overrun_d   = 1'b0;
        w_consume   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = ext(xspeed);
                    y_d     = ext(yspeed);
                    zero_d  = (xspeed == '0) && (yspeed == '0);
                    state_d = S_PRE;
                end else if (pend_full_q) begin
                    x_d       = ext(pend_x_q);
                    y_d       = ext(pend_y_q);
                    zero_d    = (pend_x_q == '0) && (pend_y_q == '0);
                    w_consume = 1'b1;
                    state_d   = S_PRE;
                end
            end
            S_PRE: begin
                // Fold the left half-plane onto the right; guard bits make -32768 safe.
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = Z180;
                end else begin
                    z_d = '0;
                end
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (y_q[XW-1]) begin
                    x_d = x_q - w_ys;
                    y_d = y_q + w_xs;
                    z_d = z_q - w_atan;
                end else begin
                    x_d = x_q + w_ys;
                    y_d = y_q - w_xs;
                    z_d = z_q + w_atan;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_POST;
                end
            end
            S_POST: begin
                if (zero_q) begin
                    mag_d = '0;
                    dir_d = '0;
                end else begin
                    mag_d = (w_mag_full > MAG_MAX) ? '1 : DW'(w_mag_full);
                    dir_d = (w_dir_full == DIR_FULL) ? '0 : DW'(w_dir_full);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                speed_d     = mag_q;
                direction_d = dir_q;
                out_valid_d = 1'b1;
                if (pend_full_q) begin
                    x_d       = ext(pend_x_q);
                    y_d       = ext(pend_y_q);
                    zero_d    = (pend_x_q == '0) && (pend_y_q == '0);
                    w_consume = 1'b1;
                    state_d   = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_consume) begin
            pend_full_d = 1'b0;
        end
        if (in_valid && (state_q != S_IDLE)) begin
            overrun_d   = pend_full_q && !w_consume;
            pend_x_d    = xspeed;
            pend_y_d    = yspeed;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            pend_full_q <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            mag_q       <= '0;
            dir_q       <= '0;
            speed_q     <= '0;
            direction_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            pend_full_q <= pend_full_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            mag_q       <= mag_d;
            dir_q       <= dir_d;
            speed_q     <= speed_d;
            direction_q <= direction_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy      = (state_q == S_PRE) || (state_q == S_ITER) || (state_q == S_POST);
    assign overrun   = overrun_q;
    assign out_valid = out_valid_q;
    assign speed     = speed_q;
    assign direction = direction_q;

endmodule
`default_nettype wire

// File: tb/tb_wind_rec2pol.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wind_rec2pol
//  Description : Self-checking bench for wind_rec2pol against a real-math model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wind_rec2pol;

    localparam int DW   = 16;
    localparam int ITER = 14;
    localparam int AW   = 24;
    localparam int LAT  = ITER + 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] xspeed;
    logic [DW-1:0] yspeed;
    logic          busy;
    logic          overrun;
    logic          out_valid;
    logic [DW-1:0] speed;
    logic [DW-1:0] direction;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ovr_cnt = 0;
    int q_at[$];
    int q_spd[$];
    int q_dir[$];

    wind_rec2pol #(.DW(DW), .ITER(ITER), .AW(AW)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .xspeed    (xspeed),
        .yspeed    (yspeed),
        .busy      (busy),
        .overrun   (overrun),
        .out_valid (out_valid),
        .speed     (speed),
        .direction (direction)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (out_valid) begin
            q_at.push_back(cyc);
            q_spd.push_back(int'(speed));
            q_dir.push_back(int'(direction));
        end
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        n_total++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int ref_speed(input logic [DW-1:0] x, input logic [DW-1:0] y);
        real xr = real'($signed(x));
        real yr = real'($signed(y));
        int  v  = $rtoi($sqrt(xr * xr + yr * yr) + 0.5);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic int ref_dir(input logic [DW-1:0] x, input logic [DW-1:0] y);
        real a;
        int  v;
        if (x == '0 && y == '0) return 0;
        a = $atan2(real'($signed(y)), real'($signed(x))) * 180.0 / 3.14159265358979;
        if (a < 0.0) a = a + 360.0;
        v = $rtoi(a * 128.0 + 0.5);
        return (v >= 46080) ? v - 46080 : v;
    endfunction

    // Directions are circular: move the expectation to the nearest wrap of the observation.
    function automatic int dir_align(input int obs, input int exp);
        if (obs - exp > 23040) return exp + 46080;
        if (exp - obs > 23040) return exp - 46080;
        return exp;
    endfunction

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, output int s);
        @(negedge clock);
        xspeed   = x;
        yspeed   = y;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        s = cyc;
    endtask

    task automatic wait_out(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic convert(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int s, at, es, ed, tol_s, tol_d;
        bit ok;
        send(x, y, s);
        wait_out(at, ok);
        if (!ok) begin
            chk({tag, " timeout"}, 0, 1, 0);
        end else begin
            es    = ref_speed(x, y);
            ed    = ref_dir(x, y);
            tol_s = (x == '0 && y == '0) ? 0 : 3;
            tol_d = (x == '0 && y == '0) ? 0 : 2;
            chk({tag, " latency"}, at - s, LAT, 0);
            chk({tag, " speed"}, int'(speed), es, tol_s);
            chk({tag, " direction"}, int'(direction), dir_align(int'(direction), ed), tol_d);
            @(negedge clock);
            chk({tag, " pulse"}, int'(out_valid), 0, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, base_q, base_o, big, oth, xi, yi;
        logic [DW-1:0] rx, ry;

        reset    = 1'b1;
        in_valid = 1'b0;
        xspeed   = '0;
        yspeed   = '0;
        repeat (3) @(negedge clock);
        chk("rst busy", int'(busy), 0, 0);
        chk("rst overrun", int'(overrun), 0, 0);
        chk("rst out_valid", int'(out_valid), 0, 0);
        chk("rst speed", int'(speed), 0, 0);
        chk("rst direction", int'(direction), 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        convert("t1 +x", 16'h0400, 16'h0000);
        convert("t2 -y", 16'h0000, 16'hFC00);
        convert("t2 -x", 16'hFC00, 16'h0000);
        convert("t3 min", 16'h8000, 16'h8000);
        convert("t3 max", 16'h7FFF, 16'h7FFF);
        convert("t4 wrap", 16'h0400, 16'hFFFF);
        convert("t4 zero", 16'h0000, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            big = $urandom_range(32767, 1024);
            if ($urandom_range(1, 0) == 1) big = -big;
            oth = int'($urandom_range(65535, 0)) - 32768;
            if ($urandom_range(1, 0) == 1) begin
                xi = big; yi = oth;
            end else begin
                xi = oth; yi = big;
            end
            if (i % 10 == 3) xi = -32768;
            rx = xi[DW-1:0];
            ry = yi[DW-1:0];
            convert($sformatf("rnd%0d", i), rx, ry);
        end

        // Three back-to-back pairs: the middle one is overwritten in the slot.
        repeat (2) @(negedge clock);
        base_q = q_at.size();
        base_o = ovr_cnt;
        @(negedge clock);
        xspeed = 16'h0400; yspeed = 16'h0400; in_valid = 1'b1;
        @(negedge clock);
        s = cyc;
        xspeed = 16'h0000; yspeed = 16'h0800;
        @(negedge clock);
        xspeed = 16'hF800; yspeed = 16'h0200;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (60) @(negedge clock);
        chk("t5 out_valid count", q_at.size() - base_q, 2, 0);
        chk("t5 overrun count", ovr_cnt - base_o, 1, 0);
        if (q_at.size() - base_q == 2) begin
            chk("t5 first latency", q_at[base_q] - s, LAT, 0);
            chk("t5 first speed", q_spd[base_q], ref_speed(16'h0400, 16'h0400), 3);
            chk("t5 first dir", q_dir[base_q], ref_dir(16'h0400, 16'h0400), 2);
            chk("t5 third latency", q_at[base_q+1] - s, 2 * LAT, 0);
            chk("t5 third speed", q_spd[base_q+1], ref_speed(16'hF800, 16'h0200), 3);
            chk("t5 third dir", q_dir[base_q+1], ref_dir(16'hF800, 16'h0200), 2);
        end

        // Abort mid-iteration.
        convert("t6 pre", 16'h0400, 16'h0400);
        send(16'h0300, 16'hFD00, s);
        for (int i = 0; i < 20 && cyc < s + 6; i++) @(negedge clock);
        chk("t6 busy before reset", int'(busy), 1, 0);
        base_q = q_at.size();
        reset = 1'b1;
        @(negedge clock);
        chk("t6 busy", int'(busy), 0, 0);
        chk("t6 out_valid", int'(out_valid), 0, 0);
        chk("t6 speed", int'(speed), 0, 0);
        chk("t6 direction", int'(direction), 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("t6 no output after abort", q_at.size() - base_q, 0, 0);
        convert("t6 fresh", 16'hFA00, 16'h0700);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
